ksa_prefix_sum: RTL

- Consumer end of the propagate/generate interface of the 16-bit Kogge-Stone adder.
- Takes per-bit p = a^b and g = a&b plus a carry-in, and runs the Kogge-Stone prefix network with one register stage per prefix level.
- Produces the sum and carry-out through a valid/ready pipeline with full backpressure.
- Sits directly downstream of the p/g generation stage in the adder datapath.

---
 rtl/ksa_prefix_sum.sv | 91 +++++++++
 1 files changed

// File: rtl/ksa_prefix_sum.sv
// ksa_prefix_sum: Kogge-Stone prefix network over p/g/cin, one valid/ready register stage per level.
// Defining KSA_OVF_EN adds the registered signed-overflow output out_ovf.
module ksa_prefix_sum #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_p,
    input  logic [WIDTH-1:0] in_g,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout
`ifdef KSA_OVF_EN
    ,
    output logic             out_ovf
`endif
);
    localparam int LEVELS = $clog2(WIDTH);

    logic [LEVELS-1:0][WIDTH-1:0] g_in, p_in, o_in, g_nx;
    logic [LEVELS-2:0][WIDTH-1:0] p_nx, gs, ps, os;
    logic [LEVELS-1:0]            c_in, v_in, vs, ld;
    logic [LEVELS-2:0]            cs;
    logic [LEVELS:0]              rdy;
    logic [WIDTH-1:0]             carry;

    assign rdy[LEVELS] = out_ready;
    assign in_ready    = rdy[0];
    assign out_valid   = vs[LEVELS-1];
    assign carry       = g_nx[LEVELS-1];

    // Stage k computes prefix level k+1 (span 2^k); the low span bits pass through.
    for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
        if (k == 0) begin : g_first
            assign g_in[k] = {in_g[WIDTH-1:1], in_g[0] | (in_p[0] & in_cin)};
            assign p_in[k] = in_p;
            assign o_in[k] = in_p;
            assign c_in[k] = in_cin;
            assign v_in[k] = in_valid;
        end else begin : g_rest
            assign g_in[k] = gs[k-1];
            assign p_in[k] = ps[k-1];
            assign o_in[k] = os[k-1];
            assign c_in[k] = cs[k-1];
            assign v_in[k] = vs[k-1];
        end
        if (k < LEVELS - 1) begin : g_p
            localparam logic [WIDTH-1:0] LOW = ~({WIDTH{1'b1}} << (1 << k));
            assign p_nx[k] = p_in[k] & ((p_in[k] << (1 << k)) | LOW);
        end
        assign g_nx[k] = g_in[k] | (p_in[k] & (g_in[k] << (1 << k)));
        assign rdy[k]  = !vs[k] | rdy[k+1];
        assign ld[k]   = v_in[k] & rdy[k];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vs       <= '0;
            gs       <= '0;
            ps       <= '0;
            os       <= '0;
            cs       <= '0;
            out_sum  <= '0;
            out_cout <= 1'b0;
`ifdef KSA_OVF_EN
            out_ovf  <= 1'b0;
`endif
        end else begin
            for (int i = 0; i < LEVELS; i++)
                if (rdy[i]) vs[i] <= v_in[i];
            for (int i = 0; i < LEVELS - 1; i++)
                if (ld[i]) begin
                    gs[i] <= g_nx[i];
                    ps[i] <= p_nx[i];
                    os[i] <= o_in[i];
                    cs[i] <= c_in[i];
                end
            if (ld[LEVELS-1]) begin
                out_sum  <= o_in[LEVELS-1] ^ {carry[WIDTH-2:0], c_in[LEVELS-1]};
                out_cout <= carry[WIDTH-1];
`ifdef KSA_OVF_EN
                out_ovf  <= carry[WIDTH-1] ^ carry[WIDTH-2];
`endif
            end
        end
    end
endmodule
